// File: rtl/muldiv_unit_pkg.sv
// Shared ALU op encoding plus the M-extension execute unit state machine encoding.
// Imported by the ALU control decoder and the multiply/divide unit.
package all_pkgs;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLT    = 5'd5,
    ALU_SLTU   = 5'd6,
    ALU_SLL    = 5'd7,
    ALU_SRL    = 5'd8,
    ALU_SRA    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } ALU_OP;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } muldiv_state_e;

  function automatic logic is_muldiv_op(input ALU_OP op);
    logic r;
    case (op)
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: r = 1'b1;
      default:                              r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_mul_op(input ALU_OP op);
    logic r;
    case (op)
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: r = 1'b1;
      default:                                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  import all_pkgs::*;

  logic            start_i;
  ALU_OP           op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic            div_by_zero_o;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i,
    input  busy_o, done_o, result_o, div_by_zero_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i,
    output busy_o, done_o, result_o, div_by_zero_o
  );

endinterface

// File: rtl/muldiv_unit_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per step.
// The dividend shifts out of the quotient register as quotient bits shift in.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            step,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] dvs_r;
  logic [XLEN:0]   shift_s;
  logic [XLEN-1:0] diff_s;
  logic            fits_s;

  // Trial subtraction; the partial remainder stays below the divisor so XLEN bits of the difference suffice
  always_comb begin
    shift_s = {rem_r, quo_r[XLEN-1]};
    fits_s  = (shift_s >= {1'b0, dvs_r});
    diff_s  = shift_s[XLEN-1:0] - dvs_r;
  end

  // Load operands, then restore or keep the partial remainder on each step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_r <= {XLEN{1'b0}};
      rem_r <= {XLEN{1'b0}};
      dvs_r <= {XLEN{1'b0}};
    end else if (load) begin
      quo_r <= dividend;
      rem_r <= {XLEN{1'b0}};
      dvs_r <= divisor;
    end else if (step) begin
      if (fits_s) begin
        rem_r <= diff_s;
        quo_r <= {quo_r[XLEN-2:0], 1'b1};
      end else begin
        rem_r <= shift_s[XLEN-1:0];
        quo_r <= {quo_r[XLEN-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M execute unit: pipelined multiplier plus iterative divider,
// sequenced by a small FSM that holds the pipeline through busy_o.
module muldiv_unit
  import all_pkgs::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave mif
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam int PW = 2 * XLEN + 2;

  muldiv_state_e   state_r;
  ALU_OP           op_r;
  logic [CW-1:0]   cnt_r;
  logic            special_r, neg_q_r, neg_r_r, rem_sel_r, dbz_r, dbz_out_r;
  logic [XLEN-1:0] spec_res_r, result_r;

  logic              accept_s, is_mul_s, is_rem_s, signed_div_s;
  logic              a_neg_s, b_neg_s, zero_s, ovf_s, special_s, mul_hi_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s, spec_res_s, mul_res_s;
  logic [XLEN-1:0]   quo_s, rem_s, quo_fix_s, rem_fix_s;
  logic signed [XLEN:0]   a_ext_s, b_ext_s;
  logic signed [PW-1:0]   prod_s;
  logic [PW-1:0]     mul_tap_s;
  logic              unused_s;

  // Request decode, divide special cases and the multiplier front end
  always_comb begin
    accept_s     = mif.start_i && (state_r == IDLE) && is_muldiv_op(mif.op_i) && !mif.flush_i;
    is_mul_s     = is_mul_op(mif.op_i);
    is_rem_s     = (mif.op_i == ALU_REM) || (mif.op_i == ALU_REMU);
    signed_div_s = (mif.op_i == ALU_DIV) || (mif.op_i == ALU_REM);
    a_neg_s      = signed_div_s && mif.a_i[XLEN-1];
    b_neg_s      = signed_div_s && mif.b_i[XLEN-1];
    a_mag_s      = a_neg_s ? -mif.a_i : mif.a_i;
    b_mag_s      = b_neg_s ? -mif.b_i : mif.b_i;
    zero_s       = (mif.b_i == {XLEN{1'b0}});
    ovf_s        = signed_div_s && (mif.a_i == {1'b1, {(XLEN-1){1'b0}}}) && (mif.b_i == {XLEN{1'b1}});
    special_s    = zero_s || ovf_s;
    if (zero_s) begin
      spec_res_s = is_rem_s ? mif.a_i : {XLEN{1'b1}};
    end else begin
      spec_res_s = is_rem_s ? {XLEN{1'b0}} : mif.a_i;
    end
    a_ext_s = {((mif.op_i == ALU_MULH) || (mif.op_i == ALU_MULHSU)) && mif.a_i[XLEN-1], mif.a_i};
    b_ext_s = {(mif.op_i == ALU_MULH) && mif.b_i[XLEN-1], mif.b_i};
    prod_s  = a_ext_s * b_ext_s;
  end

  generate
    if (MUL_LATENCY > 1) begin : g_pipe
      logic [PW-1:0] pipe_r [MUL_LATENCY-1];
      // Product pipeline; the final stage feeds result_o on the MUL -> DONE edge
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < MUL_LATENCY - 1; i++) pipe_r[i] <= {PW{1'b0}};
        end else begin
          pipe_r[0] <= prod_s;
          for (int i = 1; i < MUL_LATENCY - 1; i++) pipe_r[i] <= pipe_r[i-1];
        end
      end
      assign mul_tap_s = pipe_r[MUL_LATENCY-2];
    end else begin : g_comb
      assign mul_tap_s = prod_s;
    end
  endgenerate

  // Result selection and sign fix-up of the divider magnitudes
  always_comb begin
    mul_hi_s  = (MUL_LATENCY == 1) ? (mif.op_i != ALU_MUL) : (op_r != ALU_MUL);
    mul_res_s = mul_hi_s ? mul_tap_s[2*XLEN-1:XLEN] : mul_tap_s[XLEN-1:0];
    quo_fix_s = neg_q_r ? -quo_s : quo_s;
    rem_fix_s = neg_r_r ? -rem_s : rem_s;
    unused_s  = ^mul_tap_s[PW-1:2*XLEN];
  end

  div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept_s && !is_mul_s && !special_s),
    .dividend  (a_mag_s),
    .divisor   (b_mag_s),
    .step      (state_r == DIV),
    .quotient  (quo_s),
    .remainder (rem_s)
  );

  // Sequencing FSM and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      op_r       <= ALU_ADD;
      cnt_r      <= {CW{1'b0}};
      special_r  <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      rem_sel_r  <= 1'b0;
      dbz_r      <= 1'b0;
      dbz_out_r  <= 1'b0;
      spec_res_r <= {XLEN{1'b0}};
      result_r   <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r       <= mif.op_i;
            special_r  <= special_s;
            spec_res_r <= spec_res_s;
            rem_sel_r  <= is_rem_s;
            neg_q_r    <= (mif.op_i == ALU_DIV) && (a_neg_s != b_neg_s);
            neg_r_r    <= (mif.op_i == ALU_REM) && a_neg_s;
            dbz_r      <= !is_mul_s && zero_s;
            if (is_mul_s) begin
              if (MUL_LATENCY == 1) begin
                state_r  <= DONE;
                result_r <= mul_res_s;
              end else begin
                state_r <= MUL;
                cnt_r   <= CW'(MUL_LATENCY - 2);
              end
            end else if (special_s) begin
              state_r <= FIX;
            end else begin
              state_r <= DIV;
              cnt_r   <= CW'(XLEN - 1);
            end
          end
        end
        MUL: begin
          if (mif.flush_i) begin
            state_r <= IDLE;
          end else if (cnt_r == {CW{1'b0}}) begin
            state_r  <= DONE;
            result_r <= mul_res_s;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        DIV: begin
          if (mif.flush_i) begin
            state_r <= IDLE;
          end else if (cnt_r == {CW{1'b0}}) begin
            state_r <= FIX;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        FIX: begin
          if (mif.flush_i) begin
            state_r <= IDLE;
          end else begin
            state_r   <= DONE;
            dbz_out_r <= dbz_r;
            result_r  <= special_r ? spec_res_r : (rem_sel_r ? rem_fix_s : quo_fix_s);
          end
        end
        DONE: begin
          state_r   <= IDLE;
          dbz_out_r <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          dbz_out_r <= 1'b0;
        end
      endcase
    end
  end

  assign mif.busy_o        = accept_s || (state_r == MUL) || (state_r == DIV) || (state_r == FIX);
  assign mif.done_o        = (state_r == DONE);
  assign mif.result_o      = result_r;
  assign mif.div_by_zero_o = dbz_out_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32, MUL_LATENCY=2): vector table through a
// scoreboard queue, plus hand-written flush, busy-start, reset and non-M-op sequences.
module tb_muldiv_unit;
  import all_pkgs::*;

  localparam int XLEN = 32;
  localparam int NV   = 18;

  typedef struct {
    ALU_OP           op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] res;
    logic            dbz;
    int              lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  vec_t sb_q[$];
  vec_t vecs[NV];

  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(XLEN)) mif();

  muldiv_unit #(.XLEN(XLEN), .MUL_LATENCY(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mif   (mif)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=no_done required=done", name);
  endtask

  // Drive one op; optionally re-assert start with another op at cycle inj while busy
  task automatic run_vec(input vec_t v, input int inj);
    vec_t e;
    int   cyc;
    bit   seen;
    @(negedge clk);
    mif.op_i    = v.op;
    mif.a_i     = v.a;
    mif.b_i     = v.b;
    mif.start_i = 1'b1;
    sb_q.push_back(v);
    #1 chk("busy_accept", {63'd0, mif.busy_o}, 64'd1);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      mif.start_i = 1'b0;
      cyc++;
      if (cyc == inj) begin
        mif.start_i = 1'b1;
        mif.op_i    = ALU_MUL;
        mif.a_i     = 32'd5;
        mif.b_i     = 32'd5;
      end
      #1;
      if (mif.done_o) seen = 1'b1;
      else chk("busy_inflight", {63'd0, mif.busy_o}, 64'd1);
    end
    if (!seen) begin
      timeout_fail("done_timeout");
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else if (sb_q.size() == 0) begin
      timeout_fail("scoreboard_empty");
    end else begin
      e = sb_q.pop_front();
      chk("latency", 64'(cyc), 64'(e.lat));
      chk("result", {32'd0, mif.result_o}, {32'd0, e.res});
      chk("div_by_zero", {63'd0, mif.div_by_zero_o}, {63'd0, e.dbz});
      chk("busy_in_done", {63'd0, mif.busy_o}, 64'd0);
    end
  endtask

  // Watch n cycles and report whether any done pulse or busy appeared
  task automatic watch_quiet(input string name, input int n);
    bit any_done;
    bit any_busy;
    any_done = 1'b0;
    any_busy = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      #1;
      any_done |= mif.done_o;
      any_busy |= mif.busy_o;
    end
    chk({name, "_done"}, {63'd0, any_done}, 64'd0);
    chk({name, "_busy"}, {63'd0, any_busy}, 64'd0);
  endtask

  initial begin
    logic [XLEN-1:0] hold;
    vecs[0]  = '{ALU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 2};
    vecs[1]  = '{ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 2};
    vecs[2]  = '{ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 2};
    vecs[3]  = '{ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 2};
    vecs[4]  = '{ALU_MUL,    32'h12345678, 32'd9,        32'hA3D70A38, 1'b0, 2};
    vecs[5]  = '{ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 2};
    vecs[6]  = '{ALU_MULHU,  32'h80000000, 32'd2,        32'h00000001, 1'b0, 2};
    vecs[7]  = '{ALU_DIV,    32'hFFFFFFEC, 32'd6,        32'hFFFFFFFD, 1'b0, 34};
    vecs[8]  = '{ALU_REM,    32'hFFFFFFEC, 32'd6,        32'hFFFFFFFE, 1'b0, 34};
    vecs[9]  = '{ALU_DIVU,   32'd20,       32'd6,        32'd3,        1'b0, 34};
    vecs[10] = '{ALU_REMU,   32'd100,      32'd7,        32'd2,        1'b0, 34};
    vecs[11] = '{ALU_DIV,    32'd20,       32'hFFFFFFFA, 32'hFFFFFFFD, 1'b0, 34};
    vecs[12] = '{ALU_REM,    32'd20,       32'hFFFFFFFA, 32'd2,        1'b0, 34};
    vecs[13] = '{ALU_DIVU,   32'd123,      32'd0,        32'hFFFFFFFF, 1'b1, 2};
    vecs[14] = '{ALU_REM,    32'd123,      32'd0,        32'd123,      1'b1, 2};
    vecs[15] = '{ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 2};
    vecs[16] = '{ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 2};
    vecs[17] = '{ALU_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, 34};

    rst_n       = 1'b0;
    mif.start_i = 1'b0;
    mif.flush_i = 1'b0;
    mif.op_i    = ALU_ADD;
    mif.a_i     = 32'd0;
    mif.b_i     = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", {63'd0, mif.busy_o}, 64'd0);
    chk("reset_done", {63'd0, mif.done_o}, 64'd0);
    chk("reset_result", {32'd0, mif.result_o}, 64'd0);
    chk("reset_dbz", {63'd0, mif.div_by_zero_o}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], -1);

    // start_i while busy must not disturb the DIV in flight
    run_vec('{ALU_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 34}, 5);
    watch_quiet("after_busy_start", 5);

    // Reset at cycle 15 of a DIV
    @(negedge clk);
    mif.op_i = ALU_DIV; mif.a_i = 32'hFFFFFFEC; mif.b_i = 32'd6; mif.start_i = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      mif.start_i = 1'b0;
      if (c == 15) rst_n = 1'b0;
    end
    @(negedge clk);
    #1;
    chk("midreset_busy", {63'd0, mif.busy_o}, 64'd0);
    chk("midreset_done", {63'd0, mif.done_o}, 64'd0);
    chk("midreset_result", {32'd0, mif.result_o}, 64'd0);
    chk("midreset_dbz", {63'd0, mif.div_by_zero_o}, 64'd0);
    rst_n = 1'b1;
    run_vec('{ALU_MUL, 32'd5, 32'd5, 32'd25, 1'b0, 2}, -1);
    hold = 32'd25;

    // Flush a DIV at cycle 10
    @(negedge clk);
    mif.op_i = ALU_DIV; mif.a_i = 32'hFFFFFFEC; mif.b_i = 32'd6; mif.start_i = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      mif.start_i = 1'b0;
      if (c == 10) mif.flush_i = 1'b1;
      #1;
      if (c == 10) chk("flush_busy_before", {63'd0, mif.busy_o}, 64'd1);
    end
    @(negedge clk);
    mif.flush_i = 1'b0;
    #1;
    chk("flush_idle", {63'd0, mif.busy_o}, 64'd0);
    chk("flush_result_held", {32'd0, mif.result_o}, {32'd0, hold});
    watch_quiet("after_flush", 30);
    chk("flush_result_still", {32'd0, mif.result_o}, {32'd0, hold});

    // Flush in the accept cycle cancels the request
    @(negedge clk);
    mif.op_i = ALU_DIVU; mif.a_i = 32'd9; mif.b_i = 32'd3; mif.start_i = 1'b1; mif.flush_i = 1'b1;
    #1 chk("flush_accept_busy", {63'd0, mif.busy_o}, 64'd0);
    @(negedge clk);
    mif.start_i = 1'b0; mif.flush_i = 1'b0;
    watch_quiet("flush_accept", 40);

    // Non-M op is ignored
    @(negedge clk);
    mif.op_i = ALU_ADD; mif.a_i = 32'd1; mif.b_i = 32'd2; mif.start_i = 1'b1;
    #1 chk("nonm_busy", {63'd0, mif.busy_o}, 64'd0);
    @(negedge clk);
    mif.start_i = 1'b0;
    watch_quiet("nonm", 5);
    chk("nonm_result", {32'd0, mif.result_o}, {32'd0, hold});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
